// File: rtl/scpad_head_arb.sv
// Scratchpad request head: per-requestor skid FIFOs arbitrated (fixed priority with
// aging, or round-robin) into one registered request toward the body write crossbar.
module scpad_head_arb #(
    parameter int NUM_REQ      = 2,
    parameter int REQ_W        = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 8,
    localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*REQ_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_stall,
    input  logic                     w_stall,
    input  logic                     r_stall,
    output logic                     out_valid,
    output logic                     out_write,
    output logic [REQ_W-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic [NUM_REQ*32-1:0]    grant_cnt
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    // FIFO entry: {write, payload}
    typedef logic [REQ_W:0] entry_t;

    entry_t             mem    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr [NUM_REQ];
    logic [CNT_W-1:0]   count  [NUM_REQ];
    logic [AGE_W-1:0]   age    [NUM_REQ];
    logic [31:0]        gcnt   [NUM_REQ];
    entry_t             head   [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               consume;
    logic               load;
    logic               grant;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;

    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int off);
        return SRC_W'((int'(base) + off) % NUM_REQ);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign head[g]      = mem[g][rd_ptr[g]];
        // Stall comes from the registered count only, never from a same-cycle pop.
        assign req_stall[g] = (count[g] == CNT_W'(FIFO_DEPTH));
        assign push[g]      = req_valid[g] && !req_stall[g];
        assign eligible[g]  = (count[g] != '0) && !(head[g][REQ_W] ? w_stall : r_stall);
        assign starved[g]   = eligible[g] && (age[g] == AGE_W'(STARVE_LIMIT));
        assign pop[g]       = grant && (win_idx == SRC_W'(g));
        assign grant_cnt[g*32 +: 32] = gcnt[g];
    end

    assign consume = out_valid && !(out_write ? w_stall : r_stall);
    assign load    = !out_valid || consume;
    assign grant   = load && win_found;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        if (ARB_MODE != 0) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && eligible[rr_index(rr_ptr, j)]) begin
                    win_found = 1'b1;
                    win_idx   = rr_index(rr_ptr, j);
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && starved[i]) begin
                    win_found = 1'b1;
                    win_idx   = SRC_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && eligible[i]) begin
                    win_found = 1'b1;
                    win_idx   = SRC_W'(i);
                end
            end
        end
    end

    // NOTE: storage is not reset; emptiness is defined by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {req_write[i], req_data[i*REQ_W +: REQ_W]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_write <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= win_found;
            if (win_found) begin
                out_write <= head[win_idx][REQ_W];
                out_data  <= head[win_idx][REQ_W-1:0];
                out_src   <= win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age[i] <= '0;
            end
        end else if (grant) begin
            rr_ptr <= rr_index(win_idx, 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_idx == SRC_W'(i)) begin
                    age[i] <= '0;
                end else if (eligible[i] && age[i] != AGE_W'(STARVE_LIMIT)) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    // Counted on consumption by the body, not on load into the output register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt[i] <= '0;
            end
        end else if (consume) begin
            gcnt[out_src] <= gcnt[out_src] + 32'd1;
        end
    end

endmodule

// File: tb/tb_scpad_head_arb.sv
// Bench for scpad_head_arb: a fixed-priority instance (2 requestors) and a round-robin
// instance (4 requestors) checked every cycle against a queue-based reference model.
module tb_scpad_head_arb;
    localparam int W     = 64;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
    localparam int N_FP  = 2;
    localparam int N_RR  = 4;
    localparam int NREQ [2] = '{N_FP, N_RR};
    localparam int MODE [2] = '{0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    logic         in_valid [2][4];
    logic         in_write [2][4];
    logic [W-1:0] in_data  [2][4];
    logic         w_st [2];
    logic         r_st [2];

    logic [N_FP-1:0]   fp_valid, fp_write, fp_stall;
    logic [N_FP*W-1:0] fp_data;
    logic              fp_out_valid, fp_out_write;
    logic [W-1:0]      fp_out_data;
    logic [0:0]        fp_out_src;
    logic [N_FP*32-1:0] fp_gcnt;

    logic [N_RR-1:0]   rr_valid, rr_write, rr_stall;
    logic [N_RR*W-1:0] rr_data;
    logic              rr_out_valid, rr_out_write;
    logic [W-1:0]      rr_out_data;
    logic [1:0]        rr_out_src;
    logic [N_RR*32-1:0] rr_gcnt;

    logic         dut_ov [2];
    logic         dut_ow [2];
    logic [W-1:0] dut_od [2];
    logic [31:0]  dut_src [2];
    logic         dut_stall [2][4];
    logic [31:0]  dut_gcnt [2][4];

    for (genvar g = 0; g < 4; g++) begin : g_map
        if (g < N_FP) begin : g_fp
            assign fp_valid[g]          = in_valid[0][g];
            assign fp_write[g]          = in_write[0][g];
            assign fp_data[g*W +: W]    = in_data[0][g];
            assign dut_stall[0][g]      = fp_stall[g];
            assign dut_gcnt[0][g]       = fp_gcnt[g*32 +: 32];
        end else begin : g_fp_unused
            assign dut_stall[0][g]      = 1'b0;
            assign dut_gcnt[0][g]       = 32'd0;
        end
        assign rr_valid[g]       = in_valid[1][g];
        assign rr_write[g]       = in_write[1][g];
        assign rr_data[g*W +: W] = in_data[1][g];
        assign dut_stall[1][g]   = rr_stall[g];
        assign dut_gcnt[1][g]    = rr_gcnt[g*32 +: 32];
    end

    assign dut_ov[0] = fp_out_valid;  assign dut_ov[1] = rr_out_valid;
    assign dut_ow[0] = fp_out_write;  assign dut_ow[1] = rr_out_write;
    assign dut_od[0] = fp_out_data;   assign dut_od[1] = rr_out_data;
    assign dut_src[0] = 32'(fp_out_src);
    assign dut_src[1] = 32'(rr_out_src);

    scpad_head_arb #(.NUM_REQ(N_FP), .REQ_W(W), .FIFO_DEPTH(DEPTH), .ARB_MODE(0),
                     .STARVE_LIMIT(LIMIT)) dut_fp (
        .clk(clk), .n_rst(n_rst),
        .req_valid(fp_valid), .req_write(fp_write), .req_data(fp_data), .req_stall(fp_stall),
        .w_stall(w_st[0]), .r_stall(r_st[0]),
        .out_valid(fp_out_valid), .out_write(fp_out_write), .out_data(fp_out_data),
        .out_src(fp_out_src), .grant_cnt(fp_gcnt)
    );

    scpad_head_arb #(.NUM_REQ(N_RR), .REQ_W(W), .FIFO_DEPTH(DEPTH), .ARB_MODE(1),
                     .STARVE_LIMIT(LIMIT)) dut_rr (
        .clk(clk), .n_rst(n_rst),
        .req_valid(rr_valid), .req_write(rr_write), .req_data(rr_data), .req_stall(rr_stall),
        .w_stall(w_st[1]), .r_stall(r_st[1]),
        .out_valid(rr_out_valid), .out_write(rr_out_write), .out_data(rr_out_data),
        .out_src(rr_out_src), .grant_cnt(rr_gcnt)
    );

    // Reference model: one queue per requestor (index k*4+i), entry = {write, data}.
    logic [W:0]   q [8][$];
    logic         m_ov [2];
    logic         m_ow [2];
    logic [W-1:0] m_od [2];
    int           m_src [2];
    int           age [2][4];
    int           ptr [2];
    logic [31:0]  m_gcnt [2][4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic string nm(input int k);
        return (k == 0) ? "fp" : "rr";
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 8; j++) q[j].delete();
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 1'b0; m_ow[k] = 1'b0; m_od[k] = '0; m_src[k] = 0; ptr[k] = 0;
            for (int i = 0; i < 4; i++) begin
                age[k][i] = 0; m_gcnt[k][i] = '0;
            end
        end
    endtask

    task automatic model_step(input int k);
        int n, base, win;
        bit cons, load;
        bit elig [4];
        bit push [4];
        logic [W:0] e;
        n    = NREQ[k];
        base = k * 4;
        cons = m_ov[k] && !(m_ow[k] ? w_st[k] : r_st[k]);
        load = !m_ov[k] || cons;
        if (cons) m_gcnt[k][m_src[k]] += 32'd1;
        for (int i = 0; i < n; i++) begin
            push[i] = in_valid[k][i] && (q[base+i].size() < DEPTH);
            elig[i] = (q[base+i].size() != 0) && !(q[base+i][0][W] ? w_st[k] : r_st[k]);
        end
        if (load) begin
            win = -1;
            if (MODE[k] == 0) begin
                for (int i = 0; i < n; i++) if (win < 0 && elig[i] && age[k][i] == LIMIT) win = i;
                for (int i = 0; i < n; i++) if (win < 0 && elig[i]) win = i;
            end else begin
                for (int j = 0; j < n; j++) if (win < 0 && elig[(ptr[k] + j) % n]) win = (ptr[k] + j) % n;
            end
            if (win >= 0) begin
                e = q[base+win].pop_front();
                m_ov[k] = 1'b1; m_ow[k] = e[W]; m_od[k] = e[W-1:0]; m_src[k] = win;
                for (int i = 0; i < n; i++) begin
                    if (i == win) age[k][i] = 0;
                    else if (elig[i] && age[k][i] < LIMIT) age[k][i]++;
                end
                ptr[k] = (win + 1) % n;
            end else begin
                m_ov[k] = 1'b0;
            end
        end
        for (int i = 0; i < n; i++) if (push[i]) q[base+i].push_back({in_write[k][i], in_data[k][i]});
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s out_valid", nm(k)), dut_ov[k], m_ov[k]);
            if (m_ov[k]) begin
                check($sformatf("%s out_write", nm(k)), dut_ow[k], m_ow[k]);
                check($sformatf("%s out_data", nm(k)), dut_od[k], m_od[k]);
                check($sformatf("%s out_src", nm(k)), dut_src[k], m_src[k]);
            end
            for (int i = 0; i < NREQ[k]; i++) begin
                check($sformatf("%s req_stall[%0d]", nm(k), i), dut_stall[k][i], q[k*4+i].size() == DEPTH);
                check($sformatf("%s grant_cnt[%0d]", nm(k), i), dut_gcnt[k][i], m_gcnt[k][i]);
            end
        end
    endtask

    task automatic tick();
        if (!n_rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            w_st[k] = 1'b0; r_st[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_valid[k][i] = 1'b0; in_write[k][i] = 1'b0; in_data[k][i] = '0;
            end
        end
    endtask

    task automatic do_reset();
        idle();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        int got, idx;
        bit acc;
        logic [W-1:0] seen [$];

        idle();
        n_rst = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s reset out_valid", nm(k)), dut_ov[k], 0);
            check($sformatf("%s reset out_write", nm(k)), dut_ow[k], 0);
            check($sformatf("%s reset out_data", nm(k)), dut_od[k], 0);
            check($sformatf("%s reset out_src", nm(k)), dut_src[k], 0);
        end

        // Latency: one read on fp requestor 1 appears two edges later.
        in_valid[0][1] = 1'b1; in_data[0][1] = 64'hA5;
        tick();
        check("lat out_valid +1", fp_out_valid, 0);
        idle();
        tick();
        check("lat out_valid +2", fp_out_valid, 1);
        check("lat out_src", fp_out_src, 1);
        check("lat out_data", fp_out_data, 64'hA5);
        check("lat out_write", fp_out_write, 0);
        check("lat req_stall", fp_stall, 0);

        // Aging: requestor 1 gets every 9th grant.
        do_reset();
        got = 0;
        for (int c = 0; c < 40 && got < 27; c++) begin
            in_valid[0][0] = 1'b1; in_data[0][0] = 64'h100 + 64'(c);
            in_valid[0][1] = 1'b1; in_data[0][1] = 64'h200 + 64'(c);
            tick();
            if (fp_out_valid) begin
                check($sformatf("aging grant %0d src", got), fp_out_src, (got % 9 == 8) ? 1 : 0);
                got++;
            end
        end
        check("aging grants seen", got, 27);

        // Round-robin: all four, then only 1 and 3.
        do_reset();
        got = 0;
        for (int c = 0; c < 30 && got < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid[1][i] = 1'b1; in_data[1][i] = {32'(i), 32'(c)};
            end
            tick();
            if (rr_out_valid) begin
                check($sformatf("rr4 grant %0d src", got), rr_out_src, got % 4);
                got++;
            end
        end
        check("rr4 grants seen", got, 16);
        do_reset();
        got = 0;
        for (int c = 0; c < 20 && got < 8; c++) begin
            in_valid[1][1] = 1'b1; in_data[1][1] = 64'h1000 + 64'(c);
            in_valid[1][3] = 1'b1; in_data[1][3] = 64'h3000 + 64'(c);
            tick();
            if (rr_out_valid) begin
                check($sformatf("rr13 grant %0d src", got), rr_out_src, (got % 2 == 0) ? 1 : 3);
                got++;
            end
        end
        check("rr13 grants seen", got, 8);

        // Independent stalls: read overtakes a write held off by w_stall.
        do_reset();
        in_valid[0][0] = 1'b1; in_write[0][0] = 1'b1; in_data[0][0] = 64'h1111;
        in_valid[0][1] = 1'b1; in_write[0][1] = 1'b0; in_data[0][1] = 64'h2222;
        w_st[0] = 1'b1;
        tick();
        idle(); w_st[0] = 1'b1;
        tick();
        check("stall read first valid", fp_out_valid, 1);
        check("stall read first src", fp_out_src, 1);
        check("stall read first data", fp_out_data, 64'h2222);
        tick();
        check("stall write blocked", fp_out_valid, 0);
        w_st[0] = 1'b0;
        tick();
        check("stall write issued valid", fp_out_valid, 1);
        check("stall write issued data", fp_out_data, 64'h1111);
        check("stall write issued src", fp_out_src, 0);
        w_st[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall hold valid %0d", c), fp_out_valid, 1);
            check($sformatf("stall hold data %0d", c), fp_out_data, 64'h1111);
        end
        w_st[0] = 1'b0;
        tick();
        check("stall gcnt0", fp_gcnt[31:0], 1);
        check("stall gcnt1", fp_gcnt[63:32], 1);

        // Backpressure: four writes on requestor 0, w_stall held for a while.
        do_reset();
        idx = 0;
        seen.delete();
        for (int c = 0; c < 20; c++) begin
            w_st[0] = (c >= 2 && c < 6);
            in_valid[0][0] = (idx < 4);
            in_write[0][0] = 1'b1;
            in_data[0][0]  = 64'hB000 + 64'(idx);
            acc = in_valid[0][0] && (q[0].size() < DEPTH);
            if (fp_out_valid && !w_st[0]) seen.push_back(fp_out_data);
            tick();
            if (acc) idx++;
            if (c == 5) begin
                check("full req_stall", fp_stall[0], 1);
                check("full accepted", idx, 3);
            end
        end
        check("full consumed count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check($sformatf("full order %0d", i), seen[i], 64'hB000 + 64'(i));
        end
        check("full gcnt0", fp_gcnt[31:0], 4);

        // Reset mid-operation with a held output and non-empty FIFOs.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                w_st[k] = (c >= 2); r_st[k] = (c >= 2);
                for (int i = 0; i < 4; i++) begin
                    in_valid[k][i] = 1'b1; in_write[k][i] = 1'(i % 2); in_data[k][i] = {$urandom, $urandom};
                end
            end
            tick();
        end
        check("midrst pre out_valid", fp_out_valid, 1);
        n_rst = 1'b0;
        idle();
        tick();
        n_rst = 1'b1;
        check("midrst fp out_valid", fp_out_valid, 0);
        check("midrst rr out_valid", rr_out_valid, 0);
        check("midrst fp req_stall", fp_stall, 0);
        check("midrst rr req_stall", rr_stall, 0);
        check("midrst fp gcnt", fp_gcnt, 0);
        check("midrst rr gcnt", rr_gcnt[63:0], 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("midrst stale fp %0d", c), fp_out_valid, 0);
            check($sformatf("midrst stale rr %0d", c), rr_out_valid, 0);
        end

        // Randomized traffic on both instances, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            n_rst = ($urandom_range(0, 399) != 0);
            for (int k = 0; k < 2; k++) begin
                w_st[k] = ($urandom_range(0, 99) < 30);
                r_st[k] = ($urandom_range(0, 99) < 30);
                for (int i = 0; i < 4; i++) begin
                    in_valid[k][i] = ($urandom_range(0, 99) < 60);
                    in_write[k][i] = 1'($urandom_range(0, 1));
                    in_data[k][i]  = {$urandom, $urandom};
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scpad_head_arb.md
Name: scpad_head_arb

Overview:
- Parametrised next-generation scratchpad request head. Arbitrates NUM_REQ requestors (BE, FE, additional DMA/vector lanes) into one request stream toward the body write crossbar.
- Each requestor has a per-channel skid FIFO.
- Selectable fixed-priority (with anti-starvation aging) or round-robin mode.
- Read and write requests are independently gated by the body's r_stall / w_stall.

Parameters:
- NUM_REQ, 2, number of requestors; index 0 is highest priority in fixed mode (BE=0, FE=1).
- REQ_W, 64, request payload width in bits (opaque; carried unchanged).
- FIFO_DEPTH, 2, entries per requestor FIFO; power of two, ≥2.
- ARB_MODE, 0, 0 = fixed priority with aging; 1 = round-robin.
- STARVE_LIMIT, 8, fixed mode only: consecutive lost arbitrations before a requestor is force-promoted; ≥1.

Ports:
- clk, in, 1, clock.
- n_rst, in, 1, synchronous active-low reset.
- req_valid, in, NUM_REQ, per-requestor request valid.
- req_write, in, NUM_REQ, per-requestor: 1 = write request, 0 = read request.
- req_data, in, NUM_REQ*REQ_W, packed payloads; requestor i occupies [i*REQ_W +: REQ_W].
- req_stall, out, NUM_REQ, per-requestor backpressure (FIFO full).
- w_stall, in, 1, body cannot accept writes this cycle.
- r_stall, in, 1, body cannot accept reads this cycle.
- out_valid, out, 1, registered request valid toward body.
- out_write, out, 1, type of the out request.
- out_data, out, REQ_W, payload of the out request.
- out_src, out, $clog2(NUM_REQ) (min 1), index of the granting requestor.
- grant_cnt, out, NUM_REQ*32, per-requestor accepted-request counters, wrap at 2^32.

Behaviour:
- Reset (n_rst=0 at posedge): all FIFOs empty; req_stall=0; out_valid=0; out_write=0; out_data=0; out_src=0; RR pointer=0; aging counters=0; grant_cnt=0. Reset mid-transfer discards every queued and in-flight request; there is no partial completion.
- Enqueue: at a posedge where req_valid[i] && !req_stall[i], the {write, data} pair is pushed into FIFO i.
- req_stall[i] = (count[i]==FIFO_DEPTH), registered from count. It is not combinationally dependent on same-cycle pops, so a full FIFO stalls for one cycle even when it pops that cycle.
- Push and pop on the same FIFO in the same cycle: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Output stage: one register.
  - It is consumed when out_valid && !(out_write ? w_stall : r_stall).
  - It loads when !out_valid or it is consumed in that cycle.
  - While out_valid and the matching stall is high, out_* hold stable.
- Eligibility: FIFO i is eligible when it is non-empty and its head is not blocked. A write head is blocked while w_stall=1; a read head is blocked while r_stall=1. Stalls are sampled in the load cycle.
  - A blocked head does not block other requestors: cross-requestor reordering is allowed.
  - Order within one requestor is strictly FIFO.
- Grant: when the output stage loads and at least one FIFO is eligible, the winner's head is popped into the output register in the same cycle. Latency from an enqueue into an empty FIFO with an idle output stage to out_valid is 2 cycles.
- ARB_MODE=0 (fixed priority with aging):
  - age[i] increments (saturating at STARVE_LIMIT) each grant cycle in which i is eligible but loses; it clears when i wins.
  - Winner is the lowest index with age==STARVE_LIMIT if any exists; otherwise the lowest eligible index.
- ARB_MODE=1 (round-robin):
  - Winner is the first eligible index scanning from ptr upward with wrap.
  - On grant, ptr = winner+1 mod NUM_REQ. ptr is unchanged when there is no grant.
- grant_cnt[i] increments when a request from i is consumed by the body (not when loaded).
- No request is ever dropped or duplicated. out_src always equals the FIFO index the payload entered through.

Test Plan:
- Reset/latency: push one read on req 1 (data 0xA5) with stalls low -> out_valid at cycle +2, out_src=1, out_data=0xA5, out_write=0; req_stall stays 0; after reset all outputs are 0.
- Fixed priority + aging (STARVE_LIMIT=8): reqs 0 and 1 both continuously valid, no stalls -> req 0 wins 8 consecutive grants, req 1 wins the 9th; the pattern repeats with 1-in-9 service for req 1.
- Round-robin (ARB_MODE=1, NUM_REQ=4): all four requestors continuously valid -> out_src sequence 0,1,2,3,0,1,...; with only reqs 1 and 3 valid -> 1,3,1,3.
- Independent stalls: req 0 head is a write, req 1 head is a read, w_stall=1, r_stall=0 -> req 1's read is issued first; req 0's write issues in the cycle after w_stall drops; the held output stays stable during the stall.
- Backpressure/full: FIFO_DEPTH=2, w_stall=1, req 0 pushes 4 writes -> req_stall[0]=1 after the FIFO and output stage fill (3 accepted); release the stall -> all payloads emerge in push order, and grant_cnt[0]=4 after the 4th is consumed.
- Reset mid-operation: assert n_rst=0 while out_valid=1 and the FIFOs are non-empty -> next cycle out_valid=0, req_stall=0, grant_cnt=0; no stale payload appears after reset.
